// File: rtl/mod_step_counter.sv
// rtl/mod_step_counter.sv - modulo up/down step counter with wrap or clamp, load and clear
module mod_step_counter #(
  parameter int COUNT       = 16,
  parameter int MAX_STEP    = 1,
  parameter int SATURATE    = 0,
  parameter int RESET_VALUE = 0,
  localparam int WIDTH      = ($clog2(COUNT) > 1) ? $clog2(COUNT) : 1,
  localparam int SW         = ($clog2(MAX_STEP + 1) > 1) ? $clog2(MAX_STEP + 1) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic [SW-1:0]    i_step,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_count,
  output logic             o_ovf,
  output logic             o_unf,
  output logic             o_load_err,
  output logic             o_at_max,
  output logic             o_at_min
);

  // One extra bit so count+step and count+COUNT never overflow.
  localparam int CW = WIDTH + 1;
  localparam logic [CW-1:0]    COUNT_C    = CW'(COUNT);
  localparam logic [CW-1:0]    MAX_STEP_C = CW'(MAX_STEP);
  localparam logic [WIDTH-1:0] TOP_W      = WIDTH'(COUNT - 1);
  localparam logic [WIDTH-1:0] RESET_W    = WIDTH'(RESET_VALUE);

  if (COUNT < 2) begin : g_bad_count
    $error("mod_step_counter: COUNT must be >= 2");
  end
  if (MAX_STEP < 1 || MAX_STEP > COUNT - 1) begin : g_bad_step
    $error("mod_step_counter: MAX_STEP must be in 1..COUNT-1");
  end
  if (SATURATE != 0 && SATURATE != 1) begin : g_bad_sat
    $error("mod_step_counter: SATURATE must be 0 or 1");
  end
  if (RESET_VALUE < 0 || RESET_VALUE > COUNT - 1) begin : g_bad_reset
    $error("mod_step_counter: RESET_VALUE must be in 0..COUNT-1");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ovf_q, unf_q, err_q;
  logic             ovf_d, unf_d, err_d;
  logic [CW-1:0]    cur;
  logic [CW-1:0]    step_raw;
  logic [CW-1:0]    step_eff;
  logic [CW-1:0]    sum;
  logic [CW-1:0]    load_ext;

  // Next-state selection: clear beats load beats inc/dec; oversize steps clip to MAX_STEP.
  always_comb begin
    cur      = {1'b0, count_q};
    step_raw = CW'(i_step);
    step_eff = (step_raw > MAX_STEP_C) ? MAX_STEP_C : step_raw;
    sum      = cur + step_eff;
    load_ext = {1'b0, i_load_value};
    count_d  = count_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    err_d    = 1'b0;
    if (i_clear) begin
      count_d = RESET_W;
    end else if (i_load) begin
      if (load_ext >= COUNT_C) begin
        count_d = TOP_W;
        err_d   = 1'b1;
      end else begin
        count_d = i_load_value;
      end
    end else if ((i_inc != i_dec) && (step_eff != '0)) begin
      if (i_inc) begin
        if (sum >= COUNT_C) begin
          ovf_d   = 1'b1;
          count_d = (SATURATE != 0) ? TOP_W : WIDTH'(sum - COUNT_C);
        end else begin
          count_d = sum[WIDTH-1:0];
        end
      end else begin
        if (cur >= step_eff) begin
          count_d = WIDTH'(cur - step_eff);
        end else begin
          unf_d   = 1'b1;
          count_d = (SATURATE != 0) ? '0 : WIDTH'(cur + COUNT_C - step_eff);
        end
      end
    end
  end

  // Count and pulse registers; reset clears pulses immediately without a clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= RESET_W;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      err_q   <= err_d;
    end
  end

  assign o_count    = count_q;
  assign o_ovf      = ovf_q;
  assign o_unf      = unf_q;
  assign o_load_err = err_q;
  assign o_at_max   = (count_q == TOP_W);
  assign o_at_min   = (count_q == '0);

endmodule

// File: tb/tb_mod_step_counter.sv
// tb/tb_mod_step_counter.sv - self-checking bench for mod_step_counter across four configurations
module tb_mod_step_counter;

  typedef struct {
    bit clr, ld, inc, dec;
    int step, lv;
    int ea; bit oa, ua, la;
    int eb; bit ob, ub, lb;
  } vec_t;

  int p_count[4] = '{10, 10, 16, 17};
  int p_max[4]   = '{7, 7, 1, 16};
  int p_sat[4]   = '{0, 1, 0, 0};
  int p_rv[4]    = '{3, 3, 0, 5};
  int m_cnt[4];

  int tests  = 0;
  int failed = 0;

  logic clock   = 1'b0;
  logic reset   = 1'b0;
  logic clk_run = 1'b1;
  logic inc = 1'b0, dec = 1'b0, clr = 1'b0, ld = 1'b0;
  logic [4:0] step = '0;
  logic [4:0] lv   = '0;

  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic [4:0] cnt_d;
  logic [3:0] ovf, unf, lerr, amax, amin;

  always #5 clock = clk_run ? ~clock : 1'b0;

  mod_step_counter #(.COUNT(10), .MAX_STEP(7), .SATURATE(0), .RESET_VALUE(3)) dut_a (
    .clock(clock), .reset(reset), .i_inc(inc), .i_dec(dec), .i_step(step[2:0]),
    .i_clear(clr), .i_load(ld), .i_load_value(lv[3:0]), .o_count(cnt_a),
    .o_ovf(ovf[0]), .o_unf(unf[0]), .o_load_err(lerr[0]), .o_at_max(amax[0]), .o_at_min(amin[0]));

  mod_step_counter #(.COUNT(10), .MAX_STEP(7), .SATURATE(1), .RESET_VALUE(3)) dut_b (
    .clock(clock), .reset(reset), .i_inc(inc), .i_dec(dec), .i_step(step[2:0]),
    .i_clear(clr), .i_load(ld), .i_load_value(lv[3:0]), .o_count(cnt_b),
    .o_ovf(ovf[1]), .o_unf(unf[1]), .o_load_err(lerr[1]), .o_at_max(amax[1]), .o_at_min(amin[1]));

  mod_step_counter #(.COUNT(16), .MAX_STEP(1), .SATURATE(0), .RESET_VALUE(0)) dut_c (
    .clock(clock), .reset(reset), .i_inc(inc), .i_dec(dec), .i_step(step[0:0]),
    .i_clear(clr), .i_load(ld), .i_load_value(lv[3:0]), .o_count(cnt_c),
    .o_ovf(ovf[2]), .o_unf(unf[2]), .o_load_err(lerr[2]), .o_at_max(amax[2]), .o_at_min(amin[2]));

  mod_step_counter #(.COUNT(17), .MAX_STEP(16), .SATURATE(0), .RESET_VALUE(5)) dut_d (
    .clock(clock), .reset(reset), .i_inc(inc), .i_dec(dec), .i_step(step),
    .i_clear(clr), .i_load(ld), .i_load_value(lv), .o_count(cnt_d),
    .o_ovf(ovf[3]), .o_unf(unf[3]), .o_load_err(lerr[3]), .o_at_max(amax[3]), .o_at_min(amin[3]));

  function automatic logic [31:0] get_cnt(int k);
    case (k)
      0:       return {28'b0, cnt_a};
      1:       return {28'b0, cnt_b};
      2:       return {28'b0, cnt_c};
      default: return {27'b0, cnt_d};
    endcase
  endfunction

  function automatic logic [31:0] get_flags(int k);
    return {27'b0, ovf[k], unf[k], lerr[k], amax[k], amin[k]};
  endfunction

  function automatic logic [31:0] exp_flags(int k, bit ov, bit un, bit er, int c);
    return {27'b0, ov, un, er, c == p_count[k] - 1, c == 0};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the counter's rules.
  task automatic model(int k, output int nc, output bit ov, output bit un, output bit er);
    int c   = p_count[k];
    int mx  = p_max[k];
    int cur = m_cnt[k];
    int s   = int'(step) & ((1 << $clog2(mx + 1)) - 1);
    int v   = int'(lv) & ((1 << $clog2(c)) - 1);
    int t;
    if (s > mx) s = mx;
    ov = 0; un = 0; er = 0; nc = cur;
    if (clr) nc = p_rv[k];
    else if (ld) begin
      if (v < c) nc = v;
      else begin nc = c - 1; er = 1; end
    end else if (inc != dec && s != 0) begin
      t = inc ? cur + s : cur - s;
      if (t >= c) begin ov = 1; nc = p_sat[k] ? c - 1 : t - c; end
      else if (t < 0) begin un = 1; nc = p_sat[k] ? 0 : t + c; end
      else nc = t;
    end
  endtask

  task automatic drive(bit c, bit l, bit i, bit d, int s, int v);
    @(negedge clock);
    clr = c; ld = l; inc = i; dec = d; step = 5'(s); lv = 5'(v);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    clr = 0; ld = 0; inc = 0; dec = 0; step = '0; lv = '0;
    reset = 0;
    @(negedge clock);
    reset = 1;
    for (int k = 0; k < 4; k++) m_cnt[k] = p_rv[k];
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{0,1,0,0, 0, 8,  8,0,0,0,  8,0,0,0};
    tbl[1]  = '{0,0,1,0, 5, 0,  3,1,0,0,  9,1,0,0};
    tbl[2]  = '{0,0,0,1, 7, 0,  6,0,1,0,  2,0,0,0};
    tbl[3]  = '{0,0,1,0, 3, 0,  9,0,0,0,  5,0,0,0};
    tbl[4]  = '{0,0,1,0, 3, 0,  2,1,0,0,  8,0,0,0};
    tbl[5]  = '{0,1,0,0, 0, 12, 9,0,0,1,  9,0,0,1};
    tbl[6]  = '{0,0,1,0, 3, 0,  2,1,0,0,  9,1,0,0};
    tbl[7]  = '{0,0,1,1, 2, 0,  2,0,0,0,  9,0,0,0};
    tbl[8]  = '{1,1,1,0, 1, 5,  3,0,0,0,  3,0,0,0};
    tbl[9]  = '{0,0,1,0, 0, 0,  3,0,0,0,  3,0,0,0};
    tbl[10] = '{0,1,0,0, 0, 1,  1,0,0,0,  1,0,0,0};
    tbl[11] = '{0,0,0,1, 4, 0,  7,0,1,0,  0,0,1,0};
    tbl[12] = '{0,0,0,1, 2, 0,  5,0,0,0,  0,0,1,0};
    tbl[13] = '{0,0,0,0, 0, 0,  5,0,0,0,  0,0,0,0};
    tbl[14] = '{0,0,1,0, 7, 0,  2,1,0,0,  7,0,0,0};
    tbl[15] = '{0,0,0,1, 1, 0,  1,0,0,0,  6,0,0,0};

    // Reset state, checked while reset is held low.
    #12;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_cnt%0d", k), get_cnt(k), 32'(p_rv[k]));
      check($sformatf("reset_flags%0d", k), get_flags(k), exp_flags(k, 0, 0, 0, p_rv[k]));
    end
    do_reset();

    // Table vectors on the two COUNT=10 instances (wrap and clamp).
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].clr, tbl[i].ld, tbl[i].inc, tbl[i].dec, tbl[i].step, tbl[i].lv);
      check($sformatf("vec%0d_cnt_wrap", i), get_cnt(0), 32'(tbl[i].ea));
      check($sformatf("vec%0d_flags_wrap", i), get_flags(0), exp_flags(0, tbl[i].oa, tbl[i].ua, tbl[i].la, tbl[i].ea));
      check($sformatf("vec%0d_cnt_sat", i), get_cnt(1), 32'(tbl[i].eb));
      check($sformatf("vec%0d_flags_sat", i), get_flags(1), exp_flags(1, tbl[i].ob, tbl[i].ub, tbl[i].lb, tbl[i].eb));
    end

    // COUNT=16 step 1: twenty increments from 0.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 0, 1, 0);
      check($sformatf("inc20_%0d_cnt", i), get_cnt(2), 32'((i + 1) % 16));
      check($sformatf("inc20_%0d_ovf", i), {31'b0, ovf[2]}, {31'b0, i == 15});
    end

    // COUNT=17: top value, step clipping, wrap, and asynchronous reset with clock stopped.
    do_reset();
    drive(0, 1, 0, 0, 0, 16);
    check("c17_load16", get_cnt(3), 32'd16);
    check("c17_at_max", {31'b0, amax[3]}, 32'd1);
    drive(0, 0, 1, 0, 31, 0);
    check("c17_clip_wrap", get_cnt(3), 32'd15);
    check("c17_clip_ovf", {31'b0, ovf[3]}, 32'd1);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 31, 0);
    check("c17_clip_up", get_cnt(3), 32'd16);
    check("c17_clip_noovf", {31'b0, ovf[3]}, 32'd0);
    drive(0, 0, 1, 0, 1, 0);
    check("c17_wrap0", get_cnt(3), 32'd0);
    check("c17_wrap_ovf", {31'b0, ovf[3]}, 32'd1);
    drive(0, 1, 0, 0, 0, 16);
    drive(0, 0, 1, 0, 1, 0);
    @(negedge clock);
    clk_run = 0;
    check("c17_pulse_held", {31'b0, ovf[3]}, 32'd1);
    #3;
    reset = 0;
    #2;
    check("async_rst_cnt_d", get_cnt(3), 32'd5);
    check("async_rst_ovf_d", {31'b0, ovf[3]}, 32'd0);
    check("async_rst_cnt_a", get_cnt(0), 32'd3);
    #10;
    clk_run = 1;
    do_reset();

    // Randomized run against the reference model on all four instances.
    for (int n = 0; n < 10000; n++) begin
      int nc[4];
      bit ov[4], un[4], er[4];
      int r;
      @(negedge clock);
      r    = $urandom_range(0, 99);
      clr  = (r < 3);
      ld   = (r >= 3 && r < 15);
      inc  = $urandom_range(0, 1);
      dec  = $urandom_range(0, 1);
      step = 5'($urandom_range(0, 31));
      lv   = 5'($urandom_range(0, 31));
      for (int k = 0; k < 4; k++) model(k, nc[k], ov[k], un[k], er[k]);
      @(posedge clock);
      #1;
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rnd%0d_cnt%0d", n, k), get_cnt(k), 32'(nc[k]));
        check($sformatf("rnd%0d_flags%0d", n, k), get_flags(k), exp_flags(k, ov[k], un[k], er[k], nc[k]));
        m_cnt[k] = nc[k];
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
